// File: rtl/fir_pkg.sv
// Shared widths, sample/coefficient/accumulator types and the fixed low-pass taps
// for the 16-tap audio FIR.
package fir_pkg;

    localparam int WD_IN   = 24;
    localparam int WD_OUT  = 24;
    localparam int WD_COEF = 16;
    localparam int N_TAPS  = 16;
    localparam int FRAC    = 15;
    localparam int WD_ACC  = 44;

    typedef logic signed [WD_IN-1:0]   sample_t;
    typedef logic signed [WD_COEF-1:0] coef_t;
    typedef logic signed [WD_ACC-1:0]  acc_t;

    // Symmetric Q1.15 taps summing to 32768, giving unity DC gain.
    localparam coef_t COEFS [N_TAPS] = '{
        -16'sd64,   -16'sd128,  16'sd0,     16'sd512,
        16'sd1536,  16'sd3072,  16'sd4608,  16'sd6848,
        16'sd6848,  16'sd4608,  16'sd3072,  16'sd1536,
        16'sd512,   16'sd0,     -16'sd128,  -16'sd64
    };

endpackage

// File: rtl/fir_mac.sv
// Combinational multiply-accumulate over the delay line, then round half-up and
// saturate the Q1.15-scaled sum back to the output sample width.
module fir_mac
    import fir_pkg::*;
(
    input  logic [N_TAPS*WD_IN-1:0] taps,
    output logic [WD_OUT-1:0]       y
);

    localparam acc_t RND     = acc_t'(2 ** (FRAC - 1));
    localparam acc_t SAT_MAX = acc_t'(2 ** (WD_OUT - 1) - 1);
    localparam acc_t SAT_MIN = acc_t'(-(2 ** (WD_OUT - 1)));

    acc_t    acc;
    acc_t    rnd;
    acc_t    shr;
    sample_t xk;

    always_comb begin
        acc = '0;
        xk  = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            xk  = sample_t'(taps[k*WD_IN +: WD_IN]);
            acc = acc + acc_t'(xk) * acc_t'(COEFS[k]);
        end
        // Accumulator headroom covers the worst case, so rounding cannot overflow.
        rnd = acc + RND;
        shr = rnd >>> FRAC;
        if (shr > SAT_MAX) begin
            y = {1'b0, {(WD_OUT-1){1'b1}}};
        end else if (shr < SAT_MIN) begin
            y = {1'b1, {(WD_OUT-1){1'b0}}};
        end else begin
            y = shr[WD_OUT-1:0];
        end
    end

endmodule

// File: rtl/fir_filter.sv
// Direct-form 16-tap FIR: delay line and registered output around the MAC.
// Latency 2 edges from data_in to data_out; continuous stream, no backpressure.
module fir_filter
    import fir_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [WD_IN-1:0]  data_in,
    output logic [WD_OUT-1:0] data_out
);

    sample_t                 x_q [N_TAPS];
    sample_t                 x_d [N_TAPS];
    logic [N_TAPS*WD_IN-1:0] taps;
    logic [WD_OUT-1:0]       mac_y;
    logic [WD_OUT-1:0]       data_out_d;
    logic [WD_OUT-1:0]       data_out_q;

    always_comb begin
        x_d[0] = sample_t'(data_in);
        for (int k = 1; k < N_TAPS; k++) begin
            x_d[k] = x_q[k-1];
        end
    end

    always_comb begin
        taps = '0;
        for (int k = 0; k < N_TAPS; k++) begin
            taps[k*WD_IN +: WD_IN] = x_q[k];
        end
    end

    fir_mac u_mac (
        .taps (taps),
        .y    (mac_y)
    );

    assign data_out_d = mac_y;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_q[k] <= '0;
            end
            data_out_q <= '0;
        end else begin
            for (int k = 0; k < N_TAPS; k++) begin
                x_q[k] <= x_d[k];
            end
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;

endmodule

// File: tb/tb_fir_filter.sv
// Scoreboard bench for fir_filter: stimulus queues expected outputs from a plain
// arithmetic FIR model; a monitor pops and compares two edges after each sample.
module tb_fir_filter;

    logic        clk;
    logic        rst_n;
    logic [23:0] data_in;
    logic [23:0] data_out;

    int total;
    int bad;

    int COEF [16] = '{-64, -128, 0, 512, 1536, 3072, 4608, 6848,
                      6848, 4608, 3072, 1536, 512, 0, -128, -64};

    int          hist [16];
    logic [23:0] exp_q [$];
    bit          iss;
    bit          iss_d1;
    bit          chk;

    fir_filter dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .data_in  (data_in),
        .data_out (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [23:0] ref_out();
        longint acc;
        acc = 0;
        for (int k = 0; k < 16; k++) begin
            acc += longint'(COEF[k]) * longint'(hist[k]);
        end
        acc = (acc + 64'sd16384) >>> 15;
        if (acc > 64'sd8388607)  return 24'h7FFFFF;
        if (acc < -64'sd8388608) return 24'h800000;
        return acc[23:0];
    endfunction

    task automatic clear_hist();
        for (int k = 0; k < 16; k++) hist[k] = 0;
    endtask

    task automatic check(input string name, input logic [23:0] act, input logic [23:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %06h expected %06h at %0t", name, act, req, $time);
        end
    endtask

    // Called at a negedge; returns at the next negedge.
    task automatic drive(input logic [23:0] s, input bit use_exp, input logic [23:0] e);
        logic signed [23:0] sv;
        sv = s;
        data_in = s;
        for (int k = 15; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = int'(sv);
        exp_q.push_back(use_exp ? e : ref_out());
        iss = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: output after edge n+1 belongs to the sample captured at edge n.
    initial begin
        iss_d1 = 1'b0;
        forever begin
            @(posedge clk);
            chk    = iss_d1;
            iss_d1 = iss;
            #1;
            if (chk && !rst_n) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL scoreboard_underflow: got %06h expected none", data_out);
                end else begin
                    check("stream", data_out, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [23:0] s;
        logic [23:0] pos_pat [16];
        total   = 0;
        bad     = 0;
        iss     = 1'b0;
        rst_n   = 1'b1;
        data_in = 24'h123456;
        clear_hist();

        #1;
        check("reset_async", data_out, 24'h000000);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", data_out, 24'h000000);
        end

        // Release between edges; the next edge must capture the impulse.
        rst_n = 1'b0;
        drive(24'h400000, 1'b1, 24'hFFE000);
        check("first_after_release", data_out, 24'h000000);
        for (int k = 1; k < 20; k++) begin
            s = (k < 16) ? 24'(COEF[k] * 128) : 24'h000000;
            drive(24'h000000, 1'b1, s);
        end

        for (int i = 0; i < 20; i++) begin
            drive(24'h100000, (i >= 16), 24'h100000);
        end
        for (int i = 0; i < 20; i++) begin
            drive(24'h000000, 1'b0, 24'h0);
        end

        for (int i = 0; i < 24; i++) begin
            drive(24'h7FFFFF, (i >= 15), 24'h7FFFFF);
        end

        // Sample j lands on tap 15-j when the window is full.
        for (int j = 0; j < 16; j++) begin
            pos_pat[j] = (COEF[15-j] < 0) ? 24'h800000 : 24'h7FFFFF;
        end
        for (int j = 0; j < 16; j++) begin
            drive(pos_pat[j], (j == 15), 24'h7FFFFF);
        end
        for (int j = 0; j < 16; j++) begin
            drive(~pos_pat[j], (j == 15), 24'h800000);
        end

        for (int i = 0; i < 200; i++) begin
            drive(24'($urandom), 1'b0, 24'h0);
        end

        // Asynchronous reset between edges discards all history.
        iss = 1'b0;
        #2;
        rst_n = 1'b1;
        #1;
        check("midstream_reset_async", data_out, 24'h000000);
        exp_q.delete();
        clear_hist();
        for (int i = 0; i < 3; i++) begin
            data_in = 24'($urandom);
            @(negedge clk);
            check("midstream_reset_hold", data_out, 24'h000000);
        end
        rst_n = 1'b0;

        for (int i = 0; i < 10000; i++) begin
            drive(24'($urandom), 1'b0, 24'h0);
        end

        iss = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
